// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM state type
// and the byte/halfword lane extract and merge helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR      = 3'd3,
        ST_RESP    = 3'd4
    } lsu_state_t;

    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    return {{24{b[7]}}, b};
            F3_BU:   return {24'b0, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_HU:   return {16'b0, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [15:0] data,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
        logic [31:0] r;
        r = word;
        if (f3 == F3_B)
            r[{off, 3'b000} +: 8] = data[7:0];
        else if (f3 == F3_H)
            r[{off[1], 4'b0000} +: 16] = data;
        return r;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge,
// both operating on the word just read from memory.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    input  logic [15:0] st_data,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    assign ld_data = lane_extract(rd_word, off, funct3);
    assign st_word = lane_merge(rd_word, st_data, off, funct3);

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for a word-only registered-read data memory.
// Optional perf counters are built when LSU_PERF_CNT_EN is defined.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic [XLEN-1:0] mem_a,
    output logic [XLEN-1:0] mem_wd,
    output logic            mem_we,
    output logic            mem_re,
    input  logic [XLEN-1:0] mem_rd,
    output logic [31:0]     load_cnt,
    output logic [31:0]     store_cnt,
    output logic [31:0]     err_cnt
);

    lsu_state_t      state_q, state_d;
    logic            we_q, we_d;
    logic [2:0]      f3_q, f3_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;

    logic            f3_ok, misal, oor, acc_err;
    logic [31:0]     ld_data, st_word;

    lsu_lane_align u_align (
        .rd_word (mem_rd),
        .off     (addr_q[1:0]),
        .funct3  (f3_q),
        .st_data (wdata_q[15:0]),
        .ld_data (ld_data),
        .st_word (st_word)
    );

    // Stores only have B/H/W forms; loads add the unsigned BU/HU variants.
    always_comb begin
        f3_ok = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W);
        if (!req_we)
            f3_ok = f3_ok || (req_funct3 == F3_BU) || (req_funct3 == F3_HU);
        misal = ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00)) ||
                (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0]);
        oor     = (req_addr >= XLEN'(MEM_BYTES));
        acc_err = !f3_ok || misal || oor;
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = acc_err;
                    if (acc_err)
                        state_d = ST_RESP;
                    else if (req_we && (req_funct3 == F3_W))
                        state_d = ST_WR;
                    else
                        state_d = ST_RD_REQ;
                end
            end
            ST_RD_REQ: state_d = ST_RD_DATA;
            ST_RD_DATA: begin
                // Sub-word stores reuse the write-data register for the merged word.
                if (we_q) begin
                    wdata_d = st_word;
                    state_d = ST_WR;
                end else begin
                    rdata_d = ld_data;
                    state_d = ST_RESP;
                end
            end
            ST_WR:   state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign mem_re    = (state_q == ST_RD_REQ);
    assign mem_we    = (state_q == ST_WR);
    assign mem_a     = {addr_q[XLEN-1:2], 2'b00};
    assign mem_wd    = wdata_q;

`ifdef LSU_PERF_CNT_EN
    logic [31:0] load_cnt_q, load_cnt_d;
    logic [31:0] store_cnt_q, store_cnt_d;
    logic [31:0] err_cnt_q, err_cnt_d;

    always_comb begin
        load_cnt_d  = load_cnt_q;
        store_cnt_d = store_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (state_q == ST_RESP) begin
            if (err_q)
                err_cnt_d = err_cnt_q + 32'd1;
            else if (we_q)
                store_cnt_d = store_cnt_q + 32'd1;
            else
                load_cnt_d = load_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            load_cnt_q  <= load_cnt_d;
            store_cnt_q <= store_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign load_cnt  = load_cnt_q;
    assign store_cnt = store_cnt_q;
    assign err_cnt   = err_cnt_q;
`else
    assign load_cnt  = '0;
    assign store_cnt = '0;
    assign err_cnt   = '0;
`endif

endmodule
